// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI initiator.
package sd_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_e;

    localparam logic [7:0] FILL_BYTE = 8'hFF;
    localparam logic       MOSI_IDLE = 1'b1;
    localparam logic       SCK_IDLE  = 1'b0;

endpackage

// File: rtl/sd_spi_master_clkgen.sv
// Half-period down-counter for the SPI clock: strobes the last cycle of each
// SCK phase (phase_end_o) and the cycle just before it (near_end_o).
module spi_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk_sys,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] reload_i,
    output logic             phase_end_o,
    output logic             near_end_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? reload_i : cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        cnt_q <= cnt_d;
    end

    assign phase_end_o = run_i && (cnt_q == '0);
    assign near_end_o  = run_i && (cnt_q == DIV_W'(1));

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 initiator for an SD card: byte or 0xFF-burst transfers with a
// programmable SCK divider and chip-select writes deferred until idle.
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int LEN_W = 10,
    parameter int DIV_W = 8
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic             start,
    input  logic [7:0]       tx_data,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             abort,
    input  logic             cs_wr,
    input  logic             cs_val,
    output logic             busy,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             sd_clk,
    output logic             sd_mosi,
    output logic             sd_cs_n,
    input  logic             sd_miso
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       shift_out_q, shift_out_d;
    logic [7:0]       shift_in_q, shift_in_d;
    logic [2:0]       bit_q, bit_d;
    logic [LEN_W-1:0] bytes_left_q, bytes_left_d;
    logic             busy_q, busy_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             sd_clk_q, sd_clk_d;
    logic             sd_mosi_q, sd_mosi_d;
    logic             sd_cs_n_q, sd_cs_n_d;
    logic             cs_pend_q, cs_pend_d;
    logic             cs_pend_vld_q, cs_pend_vld_d;

    logic phase_end;
    logic near_end;
    logic start_ok;
    logic last_bit;
    logic final_byte;
    logic byte_event;

    assign start_ok   = (state_q == IDLE) && start && !abort;
    assign last_bit   = (bit_q == 3'd0);
    assign final_byte = (bytes_left_q == LEN_W'(1));
    // The byte completes as the last SCK-high cycle of bit 0 begins, so the
    // final byte already reports idle while SCK finishes its high phase.
    assign byte_event = last_bit &&
                        (((state_q == LOW) && phase_end && (div_q == '0)) ||
                         ((state_q == HIGH) && near_end));

    spi_clkgen #(
        .DIV_W(DIV_W)
    ) u_clkgen (
        .clk_sys    (clk_sys),
        .clear_i    (reset | abort),
        .load_i     (start_ok),
        .load_val_i (div),
        .run_i      (state_q != IDLE),
        .reload_i   (div_q),
        .phase_end_o(phase_end),
        .near_end_o (near_end)
    );

    // NOTE: registers update with <= only; the combinational blocks compute
    // next-state values with = so later lines see earlier results.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) state_d = LOW;
                LOW: begin
                    if (byte_event && final_byte) state_d = IDLE;
                    else if (phase_end)           state_d = HIGH;
                end
                HIGH: begin
                    if (byte_event && final_byte) state_d = IDLE;
                    else if (phase_end)           state_d = LOW;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can infer a latch.
        div_d         = div_q;
        shift_out_d   = shift_out_q;
        shift_in_d    = shift_in_q;
        bit_d         = bit_q;
        bytes_left_d  = bytes_left_q;
        busy_d        = busy_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        sd_clk_d      = sd_clk_q;
        sd_mosi_d     = sd_mosi_q;
        sd_cs_n_d     = sd_cs_n_q;
        cs_pend_d     = cs_pend_q;
        cs_pend_vld_d = cs_pend_vld_q;

        if (abort) begin
            busy_d    = 1'b0;
            sd_clk_d  = SCK_IDLE;
            sd_mosi_d = MOSI_IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_d    = 1'b0;
                    sd_clk_d  = SCK_IDLE;
                    sd_mosi_d = MOSI_IDLE;
                    if (start) begin
                        div_d        = div;
                        shift_out_d  = (burst_len == '0) ? tx_data : FILL_BYTE;
                        bytes_left_d = (burst_len == '0) ? LEN_W'(1) : burst_len;
                        bit_d        = 3'd7;
                        busy_d       = 1'b1;
                        sd_mosi_d    = shift_out_d[7];
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        sd_clk_d   = 1'b1;
                        shift_in_d = {shift_in_q[6:0], sd_miso};
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        sd_clk_d = SCK_IDLE;
                        if (last_bit) begin
                            shift_out_d = FILL_BYTE;
                            bit_d       = 3'd7;
                        end else begin
                            shift_out_d = {shift_out_q[6:0], 1'b1};
                            bit_d       = bit_q - 3'd1;
                        end
                        sd_mosi_d = shift_out_d[7];
                    end
                end
                default: ;
            endcase

            if (byte_event) begin
                rx_valid_d   = 1'b1;
                rx_data_d    = shift_in_d;
                bytes_left_d = bytes_left_q - LEN_W'(1);
                if (final_byte) begin
                    busy_d    = 1'b0;
                    sd_mosi_d = MOSI_IDLE;
                end
            end
        end

        // A chip-select write during a transfer waits until busy has dropped.
        if (cs_wr) begin
            if (busy_q) begin
                cs_pend_d     = cs_val;
                cs_pend_vld_d = 1'b1;
            end else begin
                sd_cs_n_d     = cs_val;
                cs_pend_vld_d = 1'b0;
            end
        end else if (!busy_q && cs_pend_vld_q) begin
            sd_cs_n_d     = cs_pend_q;
            cs_pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_q         <= '0;
            shift_out_q   <= FILL_BYTE;
            shift_in_q    <= '0;
            bit_q         <= 3'd7;
            bytes_left_q  <= '0;
            busy_q        <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            sd_clk_q      <= SCK_IDLE;
            sd_mosi_q     <= MOSI_IDLE;
            sd_cs_n_q     <= 1'b1;
            cs_pend_q     <= 1'b1;
            cs_pend_vld_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            shift_out_q   <= shift_out_d;
            shift_in_q    <= shift_in_d;
            bit_q         <= bit_d;
            bytes_left_q  <= bytes_left_d;
            busy_q        <= busy_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            sd_clk_q      <= sd_clk_d;
            sd_mosi_q     <= sd_mosi_d;
            sd_cs_n_q     <= sd_cs_n_d;
            cs_pend_q     <= cs_pend_d;
            cs_pend_vld_q <= cs_pend_vld_d;
        end
    end

    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sd_clk   = sd_clk_q;
    assign sd_mosi  = sd_mosi_q;
    assign sd_cs_n  = sd_cs_n_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master with an SD-style mode-0 responder model.
module tb_sd_spi_master;

    localparam int LEN_W = 10;
    localparam int DIV_W = 8;

    logic             clk_sys = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] div;
    logic             start;
    logic [7:0]       tx_data;
    logic [LEN_W-1:0] burst_len;
    logic             abort;
    logic             cs_wr;
    logic             cs_val;
    logic             busy;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             sd_clk;
    logic             sd_mosi;
    logic             sd_cs_n;
    logic             sd_miso;

    always #5 clk_sys = ~clk_sys;

    sd_spi_master #(
        .LEN_W(LEN_W),
        .DIV_W(DIV_W)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .div      (div),
        .start    (start),
        .tx_data  (tx_data),
        .burst_len(burst_len),
        .abort    (abort),
        .cs_wr    (cs_wr),
        .cs_val   (cs_val),
        .busy     (busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .sd_clk   (sd_clk),
        .sd_mosi  (sd_mosi),
        .sd_cs_n  (sd_cs_n),
        .sd_miso  (sd_miso)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: counts SCK rising edges and records the MOSI bit the card sees.
    logic       sck_prev  = 1'b0;
    logic       mosi_prev = 1'b1;
    int         sck_edges = 0;
    logic       mosi_hist [0:511];

    always @(negedge clk_sys) begin
        if (sd_clk === 1'b1 && sck_prev == 1'b0) begin
            mosi_hist[9'(sck_edges)] <= mosi_prev;
            sck_edges                <= sck_edges + 1;
        end
        sck_prev  <= (sd_clk === 1'b1);
        mosi_prev <= sd_mosi;
    end

    // Responder: presents bit 7 first and advances after each SCK rising edge.
    logic [7:0] resp_mem [0:7];
    int         resp_base = 0;
    int         miso_n;

    always_comb begin
        miso_n = sck_edges - resp_base;
        if (miso_n >= 0 && miso_n < 64)
            sd_miso = resp_mem[3'(miso_n >> 3)][3'(7 - (miso_n & 7))];
        else
            sd_miso = 1'b1;
    end

    task automatic resp_load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        for (int i = 0; i < 8; i++) resp_mem[i] = 8'hFF;
        resp_mem[0] = b0;
        resp_mem[1] = b1;
        resp_mem[2] = b2;
        resp_base   = sck_edges;
    endtask

    function automatic logic [7:0] byte_at(input int base);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], mosi_hist[9'(base + i)]};
        return b;
    endfunction

    // Per-cycle output log; index = clk_sys cycles after the start cycle.
    int         cyc;
    logic [127:0] busy_l, sck_l, mosi_l, rxv_l, cs_l;
    logic [7:0]   rxd_l [0:127];

    task automatic clear_logs();
        cyc    = 0;
        busy_l = '0;
        sck_l  = '0;
        mosi_l = '0;
        rxv_l  = '0;
        cs_l   = '0;
        for (int i = 0; i < 128; i++) rxd_l[i] = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic tick_log();
        tick();
        cyc++;
        if (cyc < 128) begin
            busy_l[7'(cyc)] = busy;
            sck_l[7'(cyc)]  = sd_clk;
            mosi_l[7'(cyc)] = sd_mosi;
            rxv_l[7'(cyc)]  = rx_valid;
            cs_l[7'(cyc)]   = sd_cs_n;
            rxd_l[7'(cyc)]  = rx_data;
        end
    endtask

    int mb;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; cs_wr = 1'b0; cs_val = 1'b0;
        div = '0; tx_data = 8'h00; burst_len = '0;
        resp_load(8'hFF, 8'hFF, 8'hFF);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_rx_data",  64'(rx_data),  64'h00);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_sd_clk",   64'(sd_clk),   64'd0);
        check("rst_sd_mosi",  64'(sd_mosi),  64'd1);
        check("rst_sd_cs_n",  64'(sd_cs_n),  64'd1);

        // Single byte, div=1: A5 out, 3C in; inputs scrambled while busy.
        resp_load(8'h3C, 8'hFF, 8'hFF);
        mb = sck_edges;
        clear_logs();
        div = 8'd1; tx_data = 8'hA5; burst_len = '0; start = 1'b1;
        tick_log();
        start = 1'b0; tx_data = 8'h00; div = 8'd7; burst_len = 10'd5;
        while (cyc < 34) tick_log();
        burst_len = '0;
        check("t1_busy_1_31",  64'($countones(busy_l[31:1])), 64'd31);
        check("t1_busy_fall",  64'(busy_l[32]), 64'd0);
        check("t1_rxv_count",  64'($countones(rxv_l[33:1])), 64'd1);
        check("t1_rxv_at_32",  64'(rxv_l[32]), 64'd1);
        check("t1_rx_data",    64'(rxd_l[32]), 64'h3C);
        check("t1_sck_edges",  64'(sck_edges - mb), 64'd8);
        check("t1_mosi_byte",  64'(byte_at(mb)), 64'hA5);
        check("t1_sck_idle",   64'(sck_l[33]), 64'd0);

        // Chip select written while idle takes effect on the next cycle.
        cs_wr = 1'b1; cs_val = 1'b0;
        check("cs_idle_before", 64'(sd_cs_n), 64'd1);
        tick();
        cs_wr = 1'b0;
        check("cs_idle_write", 64'(sd_cs_n), 64'd0);

        // Burst of 3 at div=0 with a deferred CS write at cycle 5.
        resp_load(8'h01, 8'hFE, 8'h55);
        mb = sck_edges;
        clear_logs();
        div = 8'd0; burst_len = 10'd3; tx_data = 8'h00; start = 1'b1;
        tick_log();
        start = 1'b0; burst_len = '0;
        while (cyc < 50) begin
            cs_wr  = (cyc == 5);
            cs_val = 1'b1;
            tick_log();
        end
        cs_wr = 1'b0;
        check("t2_rxv_count", 64'($countones(rxv_l[50:1])), 64'd3);
        check("t2_rxv_16_32_48", 64'({rxv_l[16], rxv_l[32], rxv_l[48]}), 64'h7);
        check("t2_rxd_16", 64'(rxd_l[16]), 64'h01);
        check("t2_rxd_32", 64'(rxd_l[32]), 64'hFE);
        check("t2_rxd_48", 64'(rxd_l[48]), 64'h55);
        check("t2_mosi_high", 64'($countones(mosi_l[48:1])), 64'd48);
        check("t2_sck_pattern", 64'(sck_l[48:1]), 64'hAAAA_AAAA_AAAA);
        check("t2_busy_47", 64'(busy_l[47]), 64'd1);
        check("t2_busy_48", 64'(busy_l[48]), 64'd0);
        check("t2_cs_held", 64'(cs_l[48]), 64'd0);
        check("t2_cs_applied", 64'(cs_l[49]), 64'd1);

        // Back-to-back: second start in the rx_valid cycle; start at 5 is ignored.
        resp_load(8'h96, 8'h5A, 8'hFF);
        mb = sck_edges;
        clear_logs();
        div = 8'd0; tx_data = 8'hC3; burst_len = '0; start = 1'b1;
        tick_log();
        start = 1'b0;
        while (cyc < 34) begin
            start   = (cyc == 16) || (cyc == 5);
            tx_data = (cyc == 16) ? 8'h40 : 8'h12;
            tick_log();
        end
        start = 1'b0;
        check("t3_rxv_count", 64'($countones(rxv_l[34:1])), 64'd2);
        check("t3_rxd_16", 64'(rxd_l[16]), 64'h96);
        check("t3_rxd_32", 64'(rxd_l[32]), 64'h5A);
        check("t3_busy_16", 64'(busy_l[16]), 64'd0);
        check("t3_busy_17", 64'(busy_l[17]), 64'd1);
        check("t3_sck_nogap", 64'(sck_l[32:1]), 64'hAAAA_AAAA);
        check("t3_mosi_b1", 64'(byte_at(mb)), 64'hC3);
        check("t3_mosi_b2", 64'(byte_at(mb + 8)), 64'h40);
        check("t3_sck_edges", 64'(sck_edges - mb), 64'd16);
        check("t3_busy_33", 64'(busy_l[33]), 64'd0);

        // Abort in the high phase of bit 4 at div=3, then abort+start together.
        resp_load(8'h00, 8'hFF, 8'hFF);
        clear_logs();
        div = 8'd3; tx_data = 8'hC3; burst_len = '0; start = 1'b1;
        tick_log();
        start = 1'b0;
        while (cyc < 60) begin
            abort  = (cyc == 30) || (cyc == 31);
            start  = (cyc == 31);
            cs_wr  = (cyc == 10);
            cs_val = 1'b0;
            tick_log();
        end
        abort = 1'b0; start = 1'b0; cs_wr = 1'b0;
        check("t4_busy_30", 64'(busy_l[30]), 64'd1);
        check("t4_sck_30", 64'(sck_l[30]), 64'd1);
        check("t4_mosi_bit4", 64'(mosi_l[30]), 64'd0);
        check("t4_abort_outs", 64'({busy_l[31], sck_l[31], mosi_l[31]}), 64'h1);
        check("t4_no_rxv", 64'($countones(rxv_l[60:1])), 64'd0);
        check("t4_rxd_kept", 64'(rxd_l[31]), 64'h5A);
        check("t4_abort_beats_start", 64'($countones(busy_l[60:32])), 64'd0);
        check("t4_cs_held", 64'(cs_l[31]), 64'd1);
        check("t4_cs_applied", 64'(cs_l[32]), 64'd0);

        // Reset during byte 2 of a 5-byte burst, with a pending CS write.
        resp_load(8'h11, 8'h22, 8'h33);
        clear_logs();
        div = 8'd1; tx_data = 8'h00; burst_len = 10'd5; start = 1'b1;
        tick_log();
        start = 1'b0; burst_len = '0;
        while (cyc < 46) begin
            reset  = (cyc == 38);
            cs_wr  = (cyc == 10);
            cs_val = 1'b0;
            tick_log();
        end
        reset = 1'b0; cs_wr = 1'b0;
        check("t5_rxd_32", 64'(rxd_l[32]), 64'h11);
        check("t5_busy_38", 64'(busy_l[38]), 64'd1);
        check("t5_rst_outs", 64'({busy_l[39], rxv_l[39], sck_l[39], mosi_l[39], cs_l[39]}), 64'h3);
        check("t5_rst_rxd", 64'(rxd_l[39]), 64'h00);
        check("t5_no_rxv", 64'($countones(rxv_l[46:33])), 64'd0);
        check("t5_pend_cleared", 64'(cs_l[45]), 64'd1);

        // A normal transfer after the reset.
        resp_load(8'h81, 8'hFF, 8'hFF);
        mb = sck_edges;
        clear_logs();
        div = 8'd0; tx_data = 8'hFF; burst_len = '0; start = 1'b1;
        tick_log();
        start = 1'b0;
        while (cyc < 18) tick_log();
        check("t6_rxv_16", 64'(rxv_l[16]), 64'd1);
        check("t6_rxd_16", 64'(rxd_l[16]), 64'h81);
        check("t6_mosi", 64'(byte_at(mb)), 64'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
